// File: rtl/mem_arb_pkg.sv
// Shared state encoding, port indices and policy constants for the
// memory-system arbiter family.
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DM = 1'b1;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

   localparam int TIMEOUT_DEF = 20;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-request picker: round-robin against last_grant, or
// fixed priority with port 1 (data memory) winning.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   input  logic prio_mode,
   output logic grant_valid,
   output logic grant_idx
);

   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = PORT_IF;
      if (prio_mode) begin
         grant_idx = req1 ? PORT_DM : PORT_IF;
      end else if (req0 && req1) begin
         // Tie: the port that did not win last time goes first.
         grant_idx = ~last_grant;
      end else begin
         grant_idx = req1 ? PORT_DM : PORT_IF;
      end
   end

endmodule

// File: rtl/mem_sys_arbiter.sv
// Two-port arbiter in front of one mem_system_hier: latches the winning
// request, holds it until Done, and routes results back to the owner only.
module mem_sys_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int PRIO_MODE = PRIO_RR,
   parameter int TIMEOUT   = TIMEOUT_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_rd,
   input  logic              p0_wr,
   input  logic              p1_rd,
   input  logic              p1_wr,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p0_din,
   input  logic [DATA_W-1:0] p1_din,
   output logic [DATA_W-1:0] p0_dout,
   output logic [DATA_W-1:0] p1_dout,
   output logic              p0_done,
   output logic              p1_done,
   output logic              p0_stall,
   output logic              p1_stall,
   output logic              p0_hit,
   output logic              p1_hit,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_done,
   input  logic              mem_stall,
   input  logic              mem_hit,
   output logic              err_both,
   output logic              err_timeout
);

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   arb_state_t        state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] din_reg;
   logic              rd_reg;
   logic              wr_reg;
   logic              owner_reg;
   logic              last_grant_reg;
   logic [7:0]        wd_reg;
   logic              err_both_reg;
   logic              err_timeout_reg;

   logic              req_rd   [2];
   logic              req_wr   [2];
   logic [ADDR_W-1:0] req_addr [2];
   logic [DATA_W-1:0] req_din  [2];
   logic              done_vec [2];
   logic              hit_vec  [2];
   logic [DATA_W-1:0] dout_vec [2];

   logic grant_valid;
   logic grant_idx;
   logic busy;

   assign req_rd[0]   = p0_rd;
   assign req_rd[1]   = p1_rd;
   assign req_wr[0]   = p0_wr;
   assign req_wr[1]   = p1_wr;
   assign req_addr[0] = p0_addr;
   assign req_addr[1] = p1_addr;
   assign req_din[0]  = p0_din;
   assign req_din[1]  = p1_din;

   mem_arb_pick u_pick (
      .req0        (p0_rd | p0_wr),
      .req1        (p1_rd | p1_wr),
      .last_grant  (last_grant_reg),
      .prio_mode   (PRIO_MODE == PRIO_FIXED),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign busy     = (state_reg == BUSY);
   assign mem_rd   = busy & rd_reg;
   assign mem_wr   = busy & wr_reg;
   assign mem_addr = addr_reg;
   assign mem_din  = din_reg;
   assign p0_stall = busy;
   assign p1_stall = busy;

   // Completion is a pass-through of the memory system, steered to the owner.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic own;
         assign own          = busy & mem_done & (owner_reg == 1'(gi));
         assign done_vec[gi] = own;
         assign hit_vec[gi]  = own & mem_hit;
         assign dout_vec[gi] = own ? mem_dout : '0;
      end
   endgenerate

   assign p0_done = done_vec[0];
   assign p1_done = done_vec[1];
   assign p0_hit  = hit_vec[0];
   assign p1_hit  = hit_vec[1];
   assign p0_dout = dout_vec[0];
   assign p1_dout = dout_vec[1];

   assign err_both    = err_both_reg;
   assign err_timeout = err_timeout_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= IDLE;
         addr_reg        <= '0;
         din_reg         <= '0;
         rd_reg          <= 1'b0;
         wr_reg          <= 1'b0;
         owner_reg       <= PORT_IF;
         last_grant_reg  <= PORT_DM;
         wd_reg          <= '0;
         err_both_reg    <= 1'b0;
         err_timeout_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!mem_stall && grant_valid) begin
                  addr_reg       <= req_addr[grant_idx];
                  din_reg        <= req_din[grant_idx];
                  // A simultaneous rd+wr is issued as a write.
                  rd_reg         <= req_rd[grant_idx] & ~req_wr[grant_idx];
                  wr_reg         <= req_wr[grant_idx];
                  owner_reg      <= grant_idx;
                  last_grant_reg <= grant_idx;
                  wd_reg         <= '0;
                  state_reg      <= BUSY;
                  if (req_rd[grant_idx] && req_wr[grant_idx]) begin
                     err_both_reg <= 1'b1;
                  end
               end
            end
            BUSY: begin
               wd_reg <= wd_reg + 8'd1;
               if (mem_done) begin
                  state_reg <= IDLE;
               end else if (wd_reg == WD_LAST) begin
                  err_timeout_reg <= 1'b1;
                  state_reg       <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
